sys_array_job_arbiter: RTL
==========================

// Module: sys_array_job_arbiter
// PURPOSE
//   Shares one sys_array_fetcher between NUM_REQ requesters. Arbitrates
//   round-robin and latches the winner's operands. Sequences the fetcher
//   through local reset -> weight load -> start -> wait for ready, then
//   returns the result to the winner with a one-cycle done pulse.
//   Sits between the host-side job sources and the fetcher instance.
// PARAMETERS
//   DATA_WIDTH  8   operand width; result elements are 2*DATA_WIDTH
//   ARRAY_W_W   2   weight matrix rows
//   ARRAY_W_L   5   weight matrix columns
//   ARRAY_A_W   5   data matrix rows
//   ARRAY_A_L   2   data matrix columns
//   NUM_REQ     2   number of requesters (>=2)
//   TIMEOUT     32  max WAIT cycles before abort (> A_L+A_W+W_W+3)
// PORTS
//   clk             in   1                     clock
//   reset_n         in   1                     synchronous, active-low reset
//   req             in   NUM_REQ               job request; held until done
//   req_data_b      in   NUM_REQ*A_W*A_L*DW    per-requester data matrix
//   req_data_w      in   NUM_REQ*W_W*W_L*DW    per-requester weight matrix
//   gnt             out  NUM_REQ               one-hot 1-cycle grant (operands captured)
//   done            out  NUM_REQ               one-hot 1-cycle job completion
//   err             out  1                     1-cycle timeout flag, coincident with done
//   result          out  W_W*A_L*2DW           last job result; valid when done pulses
//   busy            out  1                     high in every state except IDLE
//   fa_reset_n      out  1                     fetcher sync reset (active low)
//   fa_load_params  out  1                     fetcher weight-load strobe
//   fa_start_comp   out  1                     fetcher start strobe
//   fa_data_b       out  A_W*A_L*DW            latched data matrix to fetcher
//   fa_data_w       out  W_W*W_L*DW            latched weight matrix to fetcher
//   fa_ready        in   1                     fetcher ready (sticky until fetcher reset)
//   fa_out_data     in   W_W*A_L*2DW           fetcher result
// BEHAVIOUR
//   Reset values: gnt=0, done=0, err=0, result=0, busy=0, fa_load_params=0,
//     fa_start_comp=0, operand latches=0, last_idx=NUM_REQ-1, state=IDLE.
//     fa_reset_n = reset_n & (state!=ARR_RST), so the fetcher is held in
//     reset while reset_n is low.
//   States:
//   IDLE: if |req, winner = first set bit searching last_idx+1, +2, ...
//     (modulo NUM_REQ). Register idx; latch req_data_b/w[idx] into the
//     fa_data_* registers; gnt[idx]=1 next cycle. Go to ARR_RST.
//   ARR_RST (1 cycle): fa_reset_n=0. Clears the fetcher's sticky ready
//     so a stale ready from the prior job is never sampled. Go to LOAD.
//   LOAD (1 cycle): fa_load_params=1. Go to START.
//   START (1 cycle): fa_start_comp=1. Clear timer. Go to WAIT.
//   WAIT: if fa_ready==1, capture result<=fa_out_data and go to DONE.
//     Otherwise timer++. If timer==TIMEOUT-1, set err_pending and go to
//     DONE with result unchanged.
//   DONE (1 cycle): done[idx]=1 and err=err_pending. Clear err_pending.
//     Set last_idx<=idx. Go to IDLE.
//   Strobes are registered and state-decoded; each is high for exactly one
//   cycle per job. fa_data_* stay constant from grant until the next grant.
//   Latency: req seen in IDLE at edge T -> gnt at T+1, fa_reset_n low
//     T+1, load T+2, start T+3, done 1 cycle after fa_ready is sampled.
//   Boundaries:
//   - req dropped mid-job: the job still completes and done still pulses.
//   - req asserted during the DONE cycle: not arbitrated until IDLE.
//     Minimum one IDLE cycle between jobs.
//   - Single persistent requester: it is re-granted back-to-back.
//   - All requesters active: grants rotate 0,1,..,NUM_REQ-1,0.
//   - reset_n low mid-job: abort immediately, no done, all outputs return
//     to reset values; the next grant after reset goes to requester 0.
//   - Timer width: $clog2(TIMEOUT+1); it never wraps.
// TESTING
//   1. Single req[0] with identity weights and data b=k -> gnt[0] at T+1,
//      start at T+3, done[0] with result==expected product, err=0.
//   2. req=2'b11 held for 4 jobs -> gnt order 0,1,0,1; each result
//      matches its own requester's operands.
//   3. Back-to-back jobs from requester 1 -> fa_reset_n pulses low before
//      each load; second done waits for a fresh ready, never the stale one.
//   4. Model fa_ready stuck 0 -> done and err pulse together after
//      TIMEOUT WAIT cycles; result holds its previous value.
//   5. reset_n low for 1 cycle during WAIT -> no done, busy=0, all strobes
//      0; new req=2'b11 -> gnt[0] first.
//   6. req[0] dropped right after gnt -> done[0] still pulses with the
//      correct result.

Source files
------------

// File: rtl/sys_array_job_arbiter.sv
// Round-robin job arbiter sharing one systolic-array fetcher between requesters.
// Sequences the fetcher through reset, weight load, start and result wait.
module sys_array_job_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 2,
  parameter int ARRAY_W_L  = 5,
  parameter int ARRAY_A_W  = 5,
  parameter int ARRAY_A_L  = 2,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 32,
  localparam int BB = ARRAY_A_W * ARRAY_A_L * DATA_WIDTH,
  localparam int WB = ARRAY_W_W * ARRAY_W_L * DATA_WIDTH,
  localparam int RB = ARRAY_W_W * ARRAY_A_L * 2 * DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*BB-1:0] req_data_b,
  input  logic [NUM_REQ*WB-1:0] req_data_w,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [RB-1:0]        result,
  output logic                 busy,
  output logic                 fa_reset_n,
  output logic                 fa_load_params,
  output logic                 fa_start_comp,
  output logic [BB-1:0]        fa_data_b,
  output logic [WB-1:0]        fa_data_w,
  input  logic                 fa_ready,
  input  logic [RB-1:0]        fa_out_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ARR_RST, LOAD, START, WAIT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx, last_idx, pick;
  logic [TW-1:0] timer;
  logic          timeout_hit;

  // Search starts one past the previous winner so grants rotate.
  always_comb begin
    int c;
    logic found;
    pick  = last_idx;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = int'(last_idx) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[c]) begin
        pick  = IW'(c);
        found = 1'b1;
      end
    end
  end

  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ARR_RST;
      ARR_RST: state_d = LOAD;
      LOAD:    state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (fa_ready || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      idx            <= '0;
      last_idx       <= IW'(NUM_REQ - 1);
      timer          <= '0;
      gnt            <= '0;
      done           <= '0;
      err            <= 1'b0;
      result         <= '0;
      fa_load_params <= 1'b0;
      fa_start_comp  <= 1'b0;
      fa_data_b      <= '0;
      fa_data_w      <= '0;
    end else begin
      state_q        <= state_d;
      gnt            <= '0;
      done           <= '0;
      err            <= 1'b0;
      fa_load_params <= (state_q == ARR_RST);
      fa_start_comp  <= (state_q == LOAD);
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            idx       <= pick;
            gnt       <= NUM_REQ'(1) << pick;
            fa_data_b <= req_data_b[int'(pick)*BB +: BB];
            fa_data_w <= req_data_w[int'(pick)*WB +: WB];
          end
        end
        START: timer <= '0;
        WAIT: begin
          if (fa_ready) begin
            result <= fa_out_data;
            done   <= NUM_REQ'(1) << idx;
          end else if (timeout_hit) begin
            err  <= 1'b1;
            done <= NUM_REQ'(1) << idx;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: last_idx <= idx;
        default: ;
      endcase
    end
  end

  // Local reset also covers the global one so the fetcher never runs unreset.
  assign fa_reset_n = reset_n & (state_q != ARR_RST);
  assign busy       = (state_q != IDLE);

endmodule
